// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU sweep controller slice.
package alu_sweep_pkg;

  localparam int IDX_W     = 10;
  localparam int N_VECTORS = 1024;

  localparam logic [3:0] TRIG_A  = 4'hF;
  localparam logic [3:0] TRIG_B  = 4'hF;
  localparam logic [1:0] TRIG_OP = 2'b00;

  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t APPLY   = 3'd1;
  localparam state_t SETTLE  = 3'd2;
  localparam state_t COMPARE = 3'd3;
  localparam state_t DONE    = 3'd4;

  // Field order matches the vector index {A,B,op}, so an index casts straight to a drive.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } drive_t;

  typedef struct packed {
    logic [3:0] result;
    logic [2:0] flags;
  } alu_out_t;

  function automatic logic is_trigger(drive_t d);
    return (d.a == TRIG_A) && (d.b == TRIG_B) && (d.op == TRIG_OP);
  endfunction

endpackage

// File: rtl/alu_sweep_controller_if.sv
// Shared drive bus to both ALU instances and their returned results/flags.
interface alu_sweep_controller_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] clean_result;
  logic [2:0] clean_flags;
  logic [3:0] trojan_result;
  logic [2:0] trojan_flags;

  modport master (
    output alu_a, alu_b, alu_op,
    input  clean_result, clean_flags, trojan_result, trojan_flags
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output clean_result, clean_flags, trojan_result, trojan_flags
  );
endinterface

// File: rtl/alu_sweep_stats.sv
// Sweep statistics: vector/mismatch/trigger counters and first-mismatch capture.
// Latency: counts update on the edge ending the enabled cycle; clear wins over enable.
// Backpressure: none; saturating counters, one update per enabled cycle.
module alu_sweep_stats
  import alu_sweep_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             mismatch,
  input  logic             trigger,
  input  logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] vector_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] trigger_cnt,
  output logic             first_mm_valid,
  output logic [IDX_W-1:0] first_mm_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      vector_cnt     <= '0;
      mismatch_cnt   <= '0;
      trigger_cnt    <= '0;
      first_mm_valid <= 1'b0;
      first_mm_idx   <= '0;
    end else if (en) begin
      if (vector_cnt != CNT_MAX) vector_cnt <= vector_cnt + CNT_ONE;
      if (mismatch) begin
        if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + CNT_ONE;
        if (!first_mm_valid) begin
          first_mm_valid <= 1'b1;
          first_mm_idx   <= idx;
        end
      end
      if (trigger && (trigger_cnt != CNT_MAX)) trigger_cnt <= trigger_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/alu_sweep_controller.sv
// Exhaustive {A,B,op} sweep of clean vs Trojan ALU; HALT_ON_MISMATCH_EN stops at first mismatch.
// Latency: SETTLE_CYCLES+2 cycles per vector, done after 1024 vectors.
// Backpressure: none; start ignored while busy, abort returns to IDLE from any state.
module alu_sweep_controller
  import alu_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  alu_sweep_controller_if.master  alu,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        vector_cnt,
  output logic [CNT_W-1:0]        mismatch_cnt,
  output logic [CNT_W-1:0]        trigger_cnt,
  output logic                    first_mm_valid,
  output logic [IDX_W-1:0]        first_mm_idx
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_VECTORS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       settle_q;
  drive_t           drive_q;
  logic             accept;
  logic             mismatch;
  logic             halt_hit;

  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
  assign mismatch = alu_out_t'({alu.clean_result, alu.clean_flags})
                 != alu_out_t'({alu.trojan_result, alu.trojan_flags});

`ifdef HALT_ON_MISMATCH_EN
  assign halt_hit = mismatch;
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE:  if (settle_q == SETTLE_LAST) state_d = COMPARE;
      COMPARE: state_d = ((idx_q == LAST_IDX) || halt_hit) ? DONE : APPLY;
      DONE:    if (accept) state_d = APPLY;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      drive_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= (state_q == SETTLE) ? settle_q + 4'd1 : 4'd0;
      if (accept) idx_q <= '0;
      else if ((state_q == COMPARE) && (state_d == APPLY)) idx_q <= idx_q + IDX_W'(1);
      // The bus idles at zero whenever the sweep is not running.
      if ((state_d == IDLE) || (state_d == DONE)) drive_q <= '0;
      else if (state_q == APPLY) drive_q <= drive_t'(idx_q);
    end
  end

  assign alu.alu_a  = drive_q.a;
  assign alu.alu_b  = drive_q.b;
  assign alu.alu_op = drive_q.op;
  assign busy = (state_q == APPLY) || (state_q == SETTLE) || (state_q == COMPARE);
  assign done = (state_q == DONE);

  alu_sweep_stats #(.CNT_W(CNT_W)) u_stats (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (accept),
    .en             (state_q == COMPARE),
    .mismatch       (mismatch),
    .trigger        (is_trigger(drive_q)),
    .idx            (idx_q),
    .vector_cnt     (vector_cnt),
    .mismatch_cnt   (mismatch_cnt),
    .trigger_cnt    (trigger_cnt),
    .first_mm_valid (first_mm_valid),
    .first_mm_idx   (first_mm_idx)
  );

endmodule

// File: tb/tb_alu_sweep_controller.sv
// Directed bench for alu_sweep_controller with a behavioural clean ALU and selectable Trojan faults.
module tb_alu_sweep_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, first_mm_valid;
  logic [10:0] vector_cnt, mismatch_cnt, trigger_cnt;
  logic [9:0]  first_mm_idx;
  int          errors = 0;
  int          checks = 0;
  int          mode = 0;
  int          cyc;

  alu_sweep_controller_if alu_bus ();

  alu_sweep_controller #(.SETTLE_CYCLES(3), .CNT_W(11)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .alu            (alu_bus),
    .busy           (busy),
    .done           (done),
    .vector_cnt     (vector_cnt),
    .mismatch_cnt   (mismatch_cnt),
    .trigger_cnt    (trigger_cnt),
    .first_mm_valid (first_mm_valid),
    .first_mm_idx   (first_mm_idx)
  );

  always #5 clk = ~clk;

  // Clean ALU: add, sub, and, xor; Trojan = clean with result bit 0 flipped on selected vectors.
  logic [4:0] s;
  logic [9:0] drv;
  logic       inj;
  always_comb begin
    drv = {alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_op};
    case (alu_bus.alu_op)
      2'd0:    s = {1'b0, alu_bus.alu_a} + {1'b0, alu_bus.alu_b};
      2'd1:    s = {1'b0, alu_bus.alu_a} - {1'b0, alu_bus.alu_b};
      2'd2:    s = {1'b0, alu_bus.alu_a & alu_bus.alu_b};
      default: s = {1'b0, alu_bus.alu_a ^ alu_bus.alu_b};
    endcase
    inj = 1'b0;
    if (mode == 1) inj = (drv == 10'h3FC);
    if (mode == 2) inj = (drv == 10'h010) || (drv == 10'h020);
    alu_bus.clean_result  = s[3:0];
    alu_bus.clean_flags   = {s[4], s[3:0] == 4'd0,
                             (alu_bus.alu_op == 2'd0) && (alu_bus.alu_a[3] == alu_bus.alu_b[3])
                             && (s[3] != alu_bus.alu_a[3])};
    alu_bus.trojan_result = s[3:0] ^ {3'b000, inj};
    alu_bus.trojan_flags  = alu_bus.clean_flags;
  end

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0d exp=0", done); end
    checks++; if (vector_cnt !== 11'd0) begin errors++; $display("FAIL reset_vec got=%0d exp=0", vector_cnt); end
    checks++; if (first_mm_valid !== 1'b0) begin errors++; $display("FAIL reset_fmv got=%0d exp=0", first_mm_valid); end
    checks++; if (drv !== 10'd0) begin errors++; $display("FAIL reset_drive got=%0h exp=0", drv); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_sweep;
    mode = 0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy got=%0d exp=1", busy); end
    wait_done(cyc);
    checks++; if (cyc != 5120) begin errors++; $display("FAIL clean_cycles got=%0d exp=5120", cyc); end
    checks++; if (vector_cnt !== 11'd1024) begin errors++; $display("FAIL clean_vec got=%0d exp=1024", vector_cnt); end
    checks++; if (mismatch_cnt !== 11'd0) begin errors++; $display("FAIL clean_mm got=%0d exp=0", mismatch_cnt); end
    checks++; if (trigger_cnt !== 11'd1) begin errors++; $display("FAIL clean_trig got=%0d exp=1", trigger_cnt); end
    checks++; if (first_mm_valid !== 1'b0) begin errors++; $display("FAIL clean_fmv got=%0d exp=0", first_mm_valid); end
    checks++; if (busy !== 1'b0 || drv !== 10'd0) begin errors++; $display("FAIL clean_idle_bus got busy=%0d drv=%0h exp 0/0", busy, drv); end
  endtask

  task automatic test_trigger_mismatch;
    int exp_vec, exp_cyc;
`ifdef HALT_ON_MISMATCH_EN
    exp_vec = 1021; exp_cyc = 5105;
`else
    exp_vec = 1024; exp_cyc = 5120;
`endif
    mode = 1;
    pulse_start();
    wait_done(cyc);
    checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL trig_cycles got=%0d exp=%0d", cyc, exp_cyc); end
    checks++; if (int'(vector_cnt) != exp_vec) begin errors++; $display("FAIL trig_vec got=%0d exp=%0d", vector_cnt, exp_vec); end
    checks++; if (mismatch_cnt !== 11'd1) begin errors++; $display("FAIL trig_mm got=%0d exp=1", mismatch_cnt); end
    checks++; if (first_mm_valid !== 1'b1) begin errors++; $display("FAIL trig_fmv got=%0d exp=1", first_mm_valid); end
    checks++; if (first_mm_idx !== 10'h3FC) begin errors++; $display("FAIL trig_fmidx got=%0h exp=3fc", first_mm_idx); end
    checks++; if (trigger_cnt !== 11'd1) begin errors++; $display("FAIL trig_trig got=%0d exp=1", trigger_cnt); end
    mode = 0;
  endtask

  task automatic test_abort;
    mode = 0;
    pulse_start();
    repeat (14) @(negedge clk);
    checks++; if (vector_cnt !== 11'd2) begin errors++; $display("FAIL abort_pre_vec got=%0d exp=2", vector_cnt); end
    checks++; if (alu_bus.alu_op !== 2'd2) begin errors++; $display("FAIL abort_pre_op got=%0d exp=2", alu_bus.alu_op); end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%0d done=%0d exp 0/0", busy, done); end
    checks++; if (vector_cnt !== 11'd3) begin errors++; $display("FAIL abort_vec got=%0d exp=3", vector_cnt); end
    checks++; if (drv !== 10'd0) begin errors++; $display("FAIL abort_drive got=%0h exp=0", drv); end
    // start and abort together from IDLE: abort wins, counters untouched
    start = 1'b1; abort = 1'b1;
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy got=%0d exp=0", busy); end
    checks++; if (vector_cnt !== 11'd3) begin errors++; $display("FAIL abort_start_vec got=%0d exp=3", vector_cnt); end
  endtask

  task automatic test_back_to_back;
    mode = 0;
    pulse_start();
    cyc = 0;
    while (!done && cyc < 6000) begin
      start = (cyc == 100) || (cyc == 2000);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++; if (cyc != 5120) begin errors++; $display("FAIL busy_start_cycles got=%0d exp=5120", cyc); end
    checks++; if (vector_cnt !== 11'd1024) begin errors++; $display("FAIL busy_start_vec got=%0d exp=1024", vector_cnt); end
    pulse_start();
    checks++; if (vector_cnt !== 11'd0 || trigger_cnt !== 11'd0) begin errors++; $display("FAIL restart_clear got vec=%0d trig=%0d exp 0/0", vector_cnt, trigger_cnt); end
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_state got done=%0d busy=%0d exp 0/1", done, busy); end
    wait_done(cyc);
    checks++; if (cyc != 5120) begin errors++; $display("FAIL restart_cycles got=%0d exp=5120", cyc); end
    checks++; if (vector_cnt !== 11'd1024 || trigger_cnt !== 11'd1) begin errors++; $display("FAIL restart_counts got vec=%0d trig=%0d exp 1024/1", vector_cnt, trigger_cnt); end
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_abort_done got=%0d exp=0", done); end
    checks++; if (vector_cnt !== 11'd1024) begin errors++; $display("FAIL done_abort_vec got=%0d exp=1024", vector_cnt); end
  endtask

  task automatic test_reset_mid_sweep;
    mode = 0;
    pulse_start();
    repeat (16) @(negedge clk);
    checks++; if (vector_cnt !== 11'd3 || alu_bus.alu_op !== 2'd3) begin errors++; $display("FAIL mid_pre got vec=%0d op=%0d exp 3/3", vector_cnt, alu_bus.alu_op); end
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_state got busy=%0d done=%0d exp 0/0", busy, done); end
    checks++; if (vector_cnt !== 11'd0 || drv !== 10'd0) begin errors++; $display("FAIL mid_rst_out got vec=%0d drv=%0h exp 0/0", vector_cnt, drv); end
    pulse_start();
    wait_done(cyc);
    checks++; if (cyc != 5120 || vector_cnt !== 11'd1024) begin errors++; $display("FAIL mid_rst_sweep got cyc=%0d vec=%0d exp 5120/1024", cyc, vector_cnt); end
  endtask

  task automatic test_halt;
    int exp_vec, exp_mm, exp_trig, exp_cyc;
`ifdef HALT_ON_MISMATCH_EN
    exp_vec = 17; exp_mm = 1; exp_trig = 0; exp_cyc = 85;
`else
    exp_vec = 1024; exp_mm = 2; exp_trig = 1; exp_cyc = 5120;
`endif
    mode = 2;
    pulse_start();
    wait_done(cyc);
    checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL halt_cycles got=%0d exp=%0d", cyc, exp_cyc); end
    checks++; if (int'(vector_cnt) != exp_vec) begin errors++; $display("FAIL halt_vec got=%0d exp=%0d", vector_cnt, exp_vec); end
    checks++; if (int'(mismatch_cnt) != exp_mm) begin errors++; $display("FAIL halt_mm got=%0d exp=%0d", mismatch_cnt, exp_mm); end
    checks++; if (int'(trigger_cnt) != exp_trig) begin errors++; $display("FAIL halt_trig got=%0d exp=%0d", trigger_cnt, exp_trig); end
    checks++; if (first_mm_valid !== 1'b1 || first_mm_idx !== 10'h010) begin errors++; $display("FAIL halt_first got v=%0d idx=%0h exp 1/010", first_mm_valid, first_mm_idx); end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_trigger_mismatch();
    test_abort();
    test_back_to_back();
    test_reset_mid_sweep();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
